otter_trap_seq: RTL and testbench

Interrupt/return sequencer for the pipelined OTTER core. Synchronises the external `INT` line, keeps a pending flag, and takes the interrupt only at a safe boundary. To take it, the block:
- freezes fetch,
- flushes the front of the pipeline,
- drains the instructions already in execute/memory/writeback,
- pulses `INT_TAKEN` to the CSR file with the correct return PC.

It also sequences `mret` redirects to `mepc`. It sits beside the decode-stage decoder and drives the PC-write, PC-mux override and pipeline-clear controls.

---
 rtl/otter_trap_seq.sv | 86 ++++++++
 tb/tb_otter_trap_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_trap_seq.sv
// Interrupt/mret sequencer for the pipelined OTTER core: synchronises INT, holds a
// pending flag, drains the back of the pipe and hands the CSR file a trap with its return PC.
module otter_trap_seq #(
  parameter int DRAIN_CYCLES = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INT,
  input  logic        MIE,
  input  logic [31:0] DEC_PC,
  input  logic        DEC_MRET,
  input  logic        REDIRECT,
  input  logic        STALL,
  output logic        PC_WRITE,
  output logic        FLUSH,
  output logic        SEL_TRAP,
  output logic        SEL_MRET,
  output logic        INT_TAKEN,
  output logic [31:0] EPC,
  output logic        BUSY
);

  typedef enum logic [1:0] {RUN, DRAIN, TAKE, MRET} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   int_s;
  logic                   int_q;
  logic                   int_rise;
  logic                   pending;
  logic [3:0]             cnt;

  assign int_s    = sync[SYNC_STAGES-1];
  assign int_rise = int_s & ~int_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync  <= '0;
      int_q <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], INT};
      int_q <= int_s;
    end
  end

  // Pending clears in TAKE; an edge landing in that same cycle is absorbed with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      pending <= 1'b0;
      cnt     <= '0;
      EPC     <= '0;
    end else begin
      if (state == TAKE) pending <= 1'b0;
      else if (int_rise) pending <= 1'b1;
      case (state)
        RUN: begin
          if (DEC_MRET && !STALL) begin
            state <= MRET;
          end else if (pending && MIE && !REDIRECT && !STALL) begin
            state <= DRAIN;
            EPC   <= DEC_PC;
            cnt   <= 4'(DRAIN_CYCLES - 1);
          end
        end
        DRAIN: begin
          // Once committed, a falling MIE does not abort the drain.
          if (cnt == 4'd0) state <= TAKE;
          else             cnt   <= cnt - 4'd1;
        end
        TAKE:    state <= RUN;
        MRET:    state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign PC_WRITE  = (state == RUN) ? ~STALL : (state != DRAIN);
  assign FLUSH     = (state != RUN);
  assign BUSY      = (state != RUN);
  assign SEL_TRAP  = (state == TAKE);
  assign INT_TAKEN = (state == TAKE);
  assign SEL_MRET  = (state == MRET);

endmodule

// File: tb/tb_otter_trap_seq.sv
// Bench for otter_trap_seq: expected EPCs are queued when an interrupt is stimulated
// and matched against each INT_TAKEN pulse; sequencing is checked cycle by cycle.
module tb_otter_trap_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INT;
  logic        MIE;
  logic [31:0] DEC_PC;
  logic        DEC_MRET;
  logic        REDIRECT;
  logic        STALL;
  logic        PC_WRITE;
  logic        FLUSH;
  logic        SEL_TRAP;
  logic        SEL_MRET;
  logic        INT_TAKEN;
  logic [31:0] EPC;
  logic        BUSY;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          take_cnt = 0;

  otter_trap_seq #(.DRAIN_CYCLES(3), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .INT(INT), .MIE(MIE), .DEC_PC(DEC_PC),
    .DEC_MRET(DEC_MRET), .REDIRECT(REDIRECT), .STALL(STALL),
    .PC_WRITE(PC_WRITE), .FLUSH(FLUSH), .SEL_TRAP(SEL_TRAP), .SEL_MRET(SEL_MRET),
    .INT_TAKEN(INT_TAKEN), .EPC(EPC), .BUSY(BUSY)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: every trap pulse must match the oldest queued return PC.
  always @(negedge CLK) begin
    if (INT_TAKEN) begin
      take_cnt++;
      if (exp_q.size() == 0) check("unexpected_take", 32'd1, 32'd0);
      else check("take_epc", EPC, exp_q.pop_front());
      check("take_sel", {30'd0, SEL_TRAP, SEL_MRET}, 32'd2);
    end
    if (SEL_MRET) check("mret_excl", {31'd0, SEL_TRAP}, 32'd0);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_int();
    INT = 1'b1;
    step();
    INT = 1'b0;
  endtask

  task automatic wait_drain(input string tag, output int k);
    bit found;
    found = 0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (FLUSH && !PC_WRITE) begin
        found = 1;
        k = i;
        break;
      end
    end
    check({tag, "_drain_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_take(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (INT_TAKEN) begin
        found = 1;
        break;
      end
    end
    check({tag, "_take_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int first;
    int k;
    int tc;
    bit busy_seen;

    // Reset with INT already high
    RST = 1'b1; INT = 1'b1; MIE = 1'b1; DEC_PC = 32'h100;
    DEC_MRET = 1'b0; REDIRECT = 1'b0; STALL = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_outs", {27'd0, PC_WRITE, FLUSH, SEL_TRAP, SEL_MRET, INT_TAKEN}, 32'h10);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    check("rst_epc", EPC, 32'd0);
    exp_q.push_back(32'h100);
    RST = 1'b0;
    first = 0;
    tc = take_cnt;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (INT_TAKEN && first == 0) first = i;
    end
    check("rst_latency", first, 32'd7);
    repeat (10) @(negedge CLK);
    check("rst_one_take", take_cnt - tc, 32'd1);
    INT = 1'b0;

    // Basic take: three drain cycles then one trap cycle, EPC held
    step();
    DEC_PC = 32'h40;
    exp_q.push_back(32'h40);
    pulse_int();
    wait_drain("basic", k);
    check("basic_latency", k, 32'd3);
    DEC_PC = 32'h44;
    for (int d = 0; d < 3; d++) begin
      if (d > 0) @(negedge CLK);
      check("basic_drain", {28'd0, PC_WRITE, FLUSH, BUSY, INT_TAKEN}, 32'h6);
      check("basic_epc_hold", EPC, 32'h40);
    end
    @(negedge CLK);
    check("basic_take", {26'd0, PC_WRITE, FLUSH, BUSY, INT_TAKEN, SEL_TRAP, SEL_MRET}, 32'h3E);
    @(negedge CLK);
    check("basic_back_run", {30'd0, BUSY, PC_WRITE}, 32'd1);

    // Masked: pending waits while MIE=0
    step();
    MIE = 1'b0;
    DEC_PC = 32'h80;
    tc = take_cnt;
    busy_seen = 0;
    pulse_int();
    repeat (50) begin
      @(negedge CLK);
      busy_seen |= BUSY;
    end
    check("mask_busy", {31'd0, busy_seen}, 32'd0);
    check("mask_no_take", take_cnt - tc, 32'd0);
    step();
    MIE = 1'b1;
    exp_q.push_back(32'h80);
    @(negedge CLK);
    check("mask_still_run", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    check("mask_drain", {30'd0, BUSY, FLUSH}, 32'd3);
    check("mask_epc", EPC, 32'h80);
    wait_take("mask");

    // Blocking: REDIRECT for 4 cycles, STALL for 2, then clean
    step();
    REDIRECT = 1'b1;
    DEC_PC = 32'hA0;
    pulse_int();
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      DEC_PC = 32'hA4 + 32'(4 * i);
      @(negedge CLK);
      check("redir_block", {31'd0, BUSY}, 32'd0);
      step();
    end
    REDIRECT = 1'b0;
    STALL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      DEC_PC = 32'hB0 + 32'(4 * i);
      @(negedge CLK);
      check("stall_block", {30'd0, BUSY, PC_WRITE}, 32'd0);
      step();
    end
    STALL = 1'b0;
    DEC_PC = 32'hC0;
    exp_q.push_back(32'hC0);
    @(negedge CLK);
    check("clean_run", {30'd0, BUSY, PC_WRITE}, 32'd1);
    step();
    @(negedge CLK);
    check("block_drain", {31'd0, BUSY}, 32'd1);
    check("block_epc", EPC, 32'hC0);
    wait_take("block");

    // Simultaneous mret and pending interrupt: mret wins, trap follows
    step();
    REDIRECT = 1'b1;
    DEC_PC = 32'hD0;
    pulse_int();
    repeat (3) step();
    REDIRECT = 1'b0;
    DEC_MRET = 1'b1;
    DEC_PC = 32'hE0;
    step();
    DEC_MRET = 1'b0;
    DEC_PC = 32'hE4;
    exp_q.push_back(32'hE4);
    @(negedge CLK);
    check("mret_state", {27'd0, SEL_MRET, SEL_TRAP, PC_WRITE, FLUSH, BUSY}, 32'h17);
    step();
    @(negedge CLK);
    check("post_mret_run", {31'd0, BUSY}, 32'd0);
    step();
    @(negedge CLK);
    check("post_mret_drain", {30'd0, BUSY, FLUSH}, 32'd3);
    check("post_mret_epc", EPC, 32'hE4);
    wait_take("simul");

    // Reset asserted on the second drain cycle
    step();
    DEC_PC = 32'h200;
    exp_q.push_back(32'h200);
    pulse_int();
    wait_drain("rstmid", k);
    step();
    #1;
    RST = 1'b1;
    #1;
    check("rstmid_outs", {27'd0, PC_WRITE, FLUSH, SEL_TRAP, INT_TAKEN, BUSY}, 32'h10);
    check("rstmid_epc", EPC, 32'd0);
    void'(exp_q.pop_front());
    @(negedge CLK);
    RST = 1'b0;
    tc = take_cnt;
    repeat (30) @(negedge CLK);
    check("rstmid_no_take", take_cnt - tc, 32'd0);
    step();
    DEC_PC = 32'h300;
    exp_q.push_back(32'h300);
    pulse_int();
    wait_take("post_rst");
    repeat (3) step();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
